// File: rtl/logic_acc_if.sv
// Operand/result handshake bundle for logic_acc.
// out_parity exists only when LOGIC_ACC_PARITY_EN is defined.
interface logic_acc_if #(
    parameter int unsigned SIZE  = 8,
    parameter int unsigned LEN_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [SIZE-1:0]  in_a;
    logic [SIZE-1:0]  in_b;
    logic [1:0]       in_op;
    logic [LEN_W-1:0] in_len;
    logic             out_valid;
    logic             out_ready;
    logic [SIZE-1:0]  out_c;
    logic             out_zero;
    logic             busy;
`ifdef LOGIC_ACC_PARITY_EN
    logic             out_parity;
`endif

    modport master (
`ifdef LOGIC_ACC_PARITY_EN
        input  out_parity,
`endif
        output in_valid, in_a, in_b, in_op, in_len, out_ready,
        input  in_ready, out_valid, out_c, out_zero, busy
    );

    modport slave (
`ifdef LOGIC_ACC_PARITY_EN
        output out_parity,
`endif
        input  in_valid, in_a, in_b, in_op, in_len, out_ready,
        output in_ready, out_valid, out_c, out_zero, busy
    );
endinterface

// File: rtl/logic_acc.sv
// Registered bitwise logic unit (AND/OR/XOR/NOR) that folds a burst of beats into one result.
// Optional feature macro: LOGIC_ACC_PARITY_EN adds out_parity = ^out_c.
module logic_acc #(
    parameter int unsigned SIZE  = 8,
    parameter int unsigned LEN_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    logic_acc_if.slave   bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [SIZE-1:0]  acc_q,   acc_d;
    logic [LEN_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       op_q,    op_d;
    logic             beat_c;
    logic [LEN_W-1:0] len_m1_c;

    function automatic logic [SIZE-1:0] apply_op(input logic [1:0] op,
                                                 input logic [SIZE-1:0] x,
                                                 input logic [SIZE-1:0] y);
        case (op)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    assign beat_c   = bus.in_valid && bus.in_ready;
    // A length of zero behaves as a single-beat burst.
    assign len_m1_c = (bus.in_len == '0) ? '0 : bus.in_len - LEN_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (beat_c) begin
                    acc_d   = apply_op(bus.in_op, bus.in_a, bus.in_b);
                    op_d    = bus.in_op;
                    cnt_d   = len_m1_c;
                    state_d = (len_m1_c == '0) ? S_OUT : S_ACC;
                end
            end
            S_ACC: begin
                // Later beats fold in_a only; in_b/in_op/in_len are ignored.
                if (beat_c) begin
                    acc_d = apply_op(op_q, acc_q, bus.in_a);
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q != S_OUT);
    assign bus.out_valid = (state_q == S_OUT);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_c     = acc_q;
    assign bus.out_zero  = (acc_q == '0);

`ifdef LOGIC_ACC_PARITY_EN
    logic parity_q;

    // Tracks acc every cycle so it is stable whenever acc is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^acc_d;
        end
    end

    assign bus.out_parity = parity_q;
`endif
endmodule

// File: doc/logic_acc.md
Name: logic_acc

Overview:
- Parametrised successor to the gate-level bitwise OR slice in the ALU.
- Registered bitwise logic unit with op select (AND/OR/XOR/NOR) and valid/ready handshakes on both sides.
- Burst mode folds the selected op across up to 2^LEN_W-1 input beats into one result.
- Sits between the ALU operand mux and the result writeback stage.

Parameters:
- SIZE, 8, operand/result width in bits
- LEN_W, 4, width of burst length field; max burst = 2^LEN_W-1 beats

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit can accept a beat
- in_a  input  SIZE  operand A
- in_b  input  SIZE  operand B, used on first beat only
- in_op  input  2  00 AND, 01 OR, 10 XOR, 11 NOR; sampled on first beat only
- in_len  input  LEN_W  beats in burst; sampled on first beat; 0 treated as 1
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_c  output  SIZE  folded result
- out_zero  output  1  out_c == 0
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; acc, cnt, op_r cleared.
  - out_valid=0, out_c=0, out_zero=1, busy=0, in_ready=1.
- Beat accept: in_valid & in_ready on a rising edge.
- in_ready = (state != OUT). It is combinational from state only, with no dependency on in_valid.
- States and transitions:
  - IDLE, on accepted beat:
    - acc <= in_a op in_b (NOR = ~(a|b)); op_r <= in_op.
    - cnt <= max(in_len,1) - 1.
    - cnt==0 after load -> OUT; else -> ACC.
  - ACC, on accepted beat:
    - acc <= acc op_r in_a (NOR: ~(acc|in_a)); in_b ignored.
    - cnt <= cnt-1; if cnt==1 -> OUT.
    - No beat -> hold.
  - OUT: out_valid=1; out_c=acc; on out_ready -> IDLE.
- Latency: out_valid asserts the cycle after the last beat is accepted. Single-beat throughput is one result per 2 cycles.
- Backpressure: while out_valid & !out_ready, out_c and out_zero stay stable, in_ready=0, and in_valid is ignored.
- in_op, in_len and in_b changes mid-burst have no effect.
- out_zero is derived from registered acc and is valid only with out_valid; it reads 1 in IDLE after reset.
- All arithmetic is bitwise on SIZE bits; no carries, no width growth.
- Max burst is 2^LEN_W-1 beats; the counter never wraps.
- Reset mid-burst or mid-OUT aborts immediately. Partial result is discarded and out_valid drops asynchronously.
- No simultaneous-event conflicts: input accept and output accept are never possible in the same state.

Optional Feature:
- Macro LOGIC_ACC_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = XOR-reduce of out_c.
  - Registered alongside acc; reset 0.
  - Meaningful only with out_valid.
  - Held stable under backpressure.
- Undefined: port absent; no parity logic.

Test Plan:
- Single OR: op=01, len=1, a=8'hA5, b=8'h0F -> next cycle out_valid=1, out_c=8'hAF, out_zero=0, in_ready=0; out_ready=1 -> IDLE, in_ready=1.
- XOR burst: op=10, len=3, beats (a=01,b=02), a=04, a=08, in_b of later beats=FF -> out_c=8'h0F after third beat; b on beats 2-3 ignored.
- NOR burst with in_valid gaps: op=11, len=2, (a=F0,b=0F), idle 3 cycles, a=01 -> out_c=8'hFE; busy=1 throughout.
- len=0 AND: a=FF, b=00 -> treated as 1 beat; out_c=8'h00, out_zero=1 (parity=0 if enabled).
- Backpressure: after result 8'h3C, hold out_ready=0 for 5 cycles while driving in_valid=1 -> out_c stays 3C, in_ready=0, no beat consumed.
- Reset mid-burst: len=4, assert rst_n=0 after 2 beats -> out_valid=0, busy=0, in_ready=1 without a clock edge. New OR len=1, a=01, b=80 -> out_c=8'h81.
